// File: rtl/bp_dma_burst_mem.sv
// Behavioural DRAM-side burst memory behind a cache-DMA port: one packet at a time,
// streams read bursts out of storage or absorbs write bursts into it.
module bp_dma_burst_mem #(
    parameter int unsigned daddr_width_p = 32,
    parameter int unsigned fill_width_p  = 64,
    parameter int unsigned burst_len_p   = 8,
    parameter int unsigned mem_els_p     = 1024,
    parameter int unsigned read_delay_p  = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [daddr_width_p:0]   dma_pkt_i,
    input  logic                     dma_pkt_v_i,
    output logic                     dma_pkt_ready_and_o,
    input  logic [fill_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_ready_and_o,
    output logic [fill_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_ready_and_i,
    output logic                     busy_o
);

    localparam int unsigned WordOff = $clog2(fill_width_p / 8);
    localparam int unsigned IdxW    = $clog2(mem_els_p);
    localparam int unsigned CntW    = $clog2(burst_len_p) + 1;
    localparam int unsigned DlyW    = (read_delay_p > 1) ? $clog2(read_delay_p) : 1;

    localparam logic [IdxW-1:0] BaseMask = ~IdxW'(burst_len_p - 1);
    localparam logic [CntW-1:0] CntLast  = CntW'(burst_len_p - 1);
    localparam logic [DlyW-1:0] DlyLast  = DlyW'((read_delay_p > 0) ? read_delay_p - 1 : 0);

    typedef enum logic [1:0] {StIdle, StDelay, StRead, StWrite} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [IdxW-1:0]   base_q, base_d;
    logic [DlyW-1:0]   delay_q, delay_d;
    logic              mem_we;

    logic [fill_width_p-1:0] mem [mem_els_p];

    logic [daddr_width_p-1:0] word_addr;
    logic [IdxW-1:0]          pkt_base;
    logic [IdxW-1:0]          index;
    logic                     unused_addr;

    // Upper word-address bits alias onto the storage depth.
    assign word_addr   = dma_pkt_i[daddr_width_p-1:0] >> WordOff;
    assign pkt_base    = word_addr[IdxW-1:0] & BaseMask;
    assign unused_addr = ^word_addr;
    assign index       = base_q + IdxW'(count_q);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            count_q <= '0;
            base_q  <= '0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            base_q  <= base_d;
            delay_q <= delay_d;
        end
    end

    // Storage deliberately has no reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[index] <= dma_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        base_d  = base_q;
        delay_d = delay_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dma_pkt_v_i) begin
                    base_d  = pkt_base;
                    count_d = '0;
                    delay_d = '0;
                    if (dma_pkt_i[daddr_width_p]) begin
                        state_d = StWrite;
                    end else if (read_delay_p == 0) begin
                        state_d = StRead;
                    end else begin
                        state_d = StDelay;
                    end
                end
            end
            StDelay: begin
                if (delay_q == DlyLast) begin
                    state_d = StRead;
                end else begin
                    delay_d = delay_q + 1'b1;
                end
            end
            StRead: begin
                if (dma_data_ready_and_i) begin
                    if (count_q == CntLast) begin
                        state_d = StIdle;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                if (dma_data_v_i) begin
                    mem_we = 1'b1;
                    if (count_q == CntLast) begin
                        state_d = StIdle;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign dma_pkt_ready_and_o  = (state_q == StIdle) && reset_n_i;
    assign dma_data_ready_and_o = (state_q == StWrite);
    assign dma_data_v_o         = (state_q == StRead);
    assign dma_data_o           = (state_q == StRead) ? mem[index] : '0;
    assign busy_o               = (state_q != StIdle);

endmodule

// File: tb/tb_bp_dma_burst_mem.sv
// Directed bench for bp_dma_burst_mem: table of write/read bursts plus hand-written
// sequences for stalls, blocked packets and a mid-burst reset.
module tb_bp_dma_burst_mem;

    logic        clk;
    logic        reset_n;
    logic [32:0] pkt;
    logic        pkt_v;
    logic        pkt_rdy;
    logic [63:0] wdata;
    logic        wdata_v;
    logic        wdata_rdy;
    logic [63:0] rdata;
    logic        rdata_v;
    logic        rdata_rdy;
    logic        busy;

    int total = 0;
    int bad   = 0;

    bp_dma_burst_mem dut (
        .clk_i                (clk),
        .reset_n_i            (reset_n),
        .dma_pkt_i            (pkt),
        .dma_pkt_v_i          (pkt_v),
        .dma_pkt_ready_and_o  (pkt_rdy),
        .dma_data_i           (wdata),
        .dma_data_v_i         (wdata_v),
        .dma_data_ready_and_o (wdata_rdy),
        .dma_data_o           (rdata),
        .dma_data_v_o         (rdata_v),
        .dma_data_ready_and_i (rdata_rdy),
        .busy_o               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] pat;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [63:0] word_of(input logic [63:0] pat, input int i);
        return pat * 64'(i + 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the packet handshake.
    task automatic send_pkt(input bit wr, input logic [31:0] addr);
        int n = 0;
        pkt   = {wr, addr};
        pkt_v = 1'b1;
        while (!pkt_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!pkt_rdy) chk("pkt_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        pkt_v = 1'b0;
    endtask

    task automatic write_burst(input logic [63:0] pat);
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            wdata_v = 1'b1;
            wdata   = word_of(pat, i);
            while (!wdata_rdy && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!wdata_rdy) chk("wr_beat_timeout", 64'd0, 64'd1);
            @(negedge clk);
        end
        wdata_v = 1'b0;
    endtask

    // Beats below split use pat_a, the rest pat_b; exp_lat < 0 skips the latency check.
    task automatic collect_read(input logic [63:0] pat_a, input logic [63:0] pat_b,
                                input int split, input int exp_lat);
        int lat = 1;
        rdata_rdy = 1'b1;
        while (!rdata_v && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (exp_lat >= 0) chk("read_latency", 64'(lat), 64'(exp_lat));
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            while (!rdata_v && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("rd_beat%0d", i), rdata,
                (i < split) ? word_of(pat_a, i) : word_of(pat_b, i));
            @(negedge clk);
        end
        chk("idle_after_read", 64'(pkt_rdy), 64'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        pkt       = '0;
        pkt_v     = 1'b0;
        wdata     = '0;
        wdata_v   = 1'b0;
        rdata_rdy = 1'b0;

        vecs[0] = '{wr: 1'b1, addr: 32'h0000_0100, pat: 64'h11};
        vecs[1] = '{wr: 1'b0, addr: 32'h0000_0100, pat: 64'h11};
        vecs[2] = '{wr: 1'b0, addr: 32'h0000_013C, pat: 64'h11};
        vecs[3] = '{wr: 1'b1, addr: 32'h0001_0100, pat: 64'hA5};
        vecs[4] = '{wr: 1'b0, addr: 32'h0000_0100, pat: 64'hA5};
        vecs[5] = '{wr: 1'b1, addr: 32'h0001_0000, pat: 64'h3C};
        vecs[6] = '{wr: 1'b0, addr: 32'h0000_0000, pat: 64'h3C};
        vecs[7] = '{wr: 1'b0, addr: 32'h0000_013C, pat: 64'hA5};

        #1;
        chk("rst_pkt_rdy", 64'(pkt_rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata_v", 64'(rdata_v), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pkt_rdy", 64'(pkt_rdy), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Write data offered in IDLE must not be taken.
        wdata_v = 1'b1;
        wdata   = 64'hDEAD;
        #1;
        chk("idle_wdata_rdy", 64'(wdata_rdy), 64'd0);
        wdata_v = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            send_pkt(vecs[v].wr, vecs[v].addr);
            if (vecs[v].wr) write_burst(vecs[v].pat);
            else            collect_read(vecs[v].pat, vecs[v].pat, 8, 3);
        end

        // Stall at beat 3: data must hold and no beat may be skipped or repeated.
        send_pkt(1'b0, 32'h0000_0100);
        rdata_rdy = 1'b1;
        for (int n = 0; n < 100 && !rdata_v; n++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_pre%0d", i), rdata, word_of(64'hA5, i));
            @(negedge clk);
        end
        rdata_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_hold", rdata, word_of(64'hA5, 3));
            chk("stall_v", 64'(rdata_v), 64'd1);
            chk("stall_pkt_rdy", 64'(pkt_rdy), 64'd0);
            @(negedge clk);
        end
        rdata_rdy = 1'b1;
        for (int i = 3; i < 8; i++) begin
            chk($sformatf("stall_post%0d", i), rdata, word_of(64'hA5, i));
            @(negedge clk);
        end
        chk("stall_idle", 64'(busy), 64'd0);

        // A read packet held during a write burst waits for the IDLE cycle.
        send_pkt(1'b1, 32'h0000_0200);
        pkt   = {1'b0, 32'h0000_0200};
        pkt_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wdata_v = 1'b1;
            wdata   = word_of(64'h77, i);
            chk("held_pkt_blocked", 64'(pkt_rdy), 64'd0);
            for (int n = 0; n < 100 && !wdata_rdy; n++) @(negedge clk);
            @(negedge clk);
        end
        wdata_v = 1'b0;
        chk("held_pkt_idle_rdy", 64'(pkt_rdy), 64'd1);
        @(negedge clk);
        pkt_v = 1'b0;
        chk("held_pkt_taken", 64'(busy), 64'd1);
        collect_read(64'h77, 64'h77, 8, 3);

        // Reset in the middle of a write burst.
        send_pkt(1'b1, 32'h0000_0300);
        write_burst(64'h21);
        send_pkt(1'b1, 32'h0000_0300);
        for (int i = 0; i < 4; i++) begin
            wdata_v = 1'b1;
            wdata   = word_of(64'h43, i);
            for (int n = 0; n < 100 && !wdata_rdy; n++) @(negedge clk);
            @(negedge clk);
        end
        wdata   = word_of(64'h43, 4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pkt_rdy", 64'(pkt_rdy), 64'd0);
        chk("mid_rst_wdata_rdy", 64'(wdata_rdy), 64'd0);
        chk("mid_rst_rdata_v", 64'(rdata_v), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        @(negedge clk);
        wdata_v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_release_rdy", 64'(pkt_rdy), 64'd1);
        send_pkt(1'b0, 32'h0000_0300);
        collect_read(64'h43, 64'h21, 4, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
